serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: bit, default 4, operand and result width in bits (bit >= 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous reset, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 I_A  input  bit  minuend, parallel load, sampled on accepted start.
REQ-006 I_B  input  bit  subtrahend, parallel load, sampled on accepted start.
REQ-007 result  output  bit  difference register (A - B mod 2^bit), LSB-first serial fill.
REQ-008 borrow_out  output  1  final borrow; 1 iff I_A < I_B (unsigned).
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle pulse; result and borrow_out valid.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; state, shift registers A and B, borrow flip-flop and bit counter are all registered on clk.
REQ-012 IDLE: start=1 at a rising edge -> A<=I_A, B<=I_B, borrow<=0, count<=0, state<=SHIFT; start=0 -> remain IDLE, all registers hold.
REQ-013 SHIFT, each edge: d = A[0]^B[0]^borrow; borrow <= (~A[0]&B[0]) | (~(A[0]^B[0])&borrow); A <= {d, A[bit-1:1]}; B <= {1'b0, B[bit-1:1]}; count <= count+1.
REQ-014 SHIFT lasts exactly bit edges; the edge that performs shift number bit sets state<=DONE.
REQ-015 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-016 Latency: start accepted at edge N -> done high in the cycle following edge N+bit; next start accepted no earlier than edge N+bit+2.
REQ-017 start in SHIFT or DONE is ignored; operands in flight are not reloaded, and no request is queued.
REQ-018 I_A/I_B changes outside the accepting edge have no effect.
REQ-019 result = A register at all times; only the value while done=1 and thereafter in IDLE is defined as valid; intermediate values during SHIFT are don't-care for checking.
REQ-020 borrow_out = borrow flip-flop; valid while done=1 and held in IDLE until the next accepted start.
REQ-021 result and borrow_out hold after DONE until the next accepted start.
REQ-022 Arithmetic is unsigned modulo 2^bit; wrap-around on underflow is signalled only by borrow_out.
REQ-023 Bit counter width ceil(log2(bit+1)); the counter does not overflow for any legal bit.
REQ-024 busy=1 exactly in SHIFT; done=1 exactly in DONE; busy and done are never both high.

Reset
REQ-025 reset=1 immediately (without waiting for clk) forces state=IDLE, A=0, B=0, borrow=0, count=0; therefore result=0, borrow_out=0, busy=0, done=0.
REQ-026 Reset asserted mid-SHIFT or in DONE aborts the operation; no done pulse is produced for the aborted operation.
REQ-027 After reset deasserts, the first rising edge with start=1 is accepted normally.
REQ-028 start is ignored while reset=1.

Verification (bit=4)
REQ-029 I_A=7, I_B=3, start pulse -> busy for 4 cycles, then done pulse with result=4, borrow_out=0.
REQ-030 I_A=3, I_B=7 -> result=12 (0xC), borrow_out=1; then I_A=0, I_B=1 -> result=15, borrow_out=1.
REQ-031 I_A=15, I_B=15 -> result=0, borrow_out=0; I_A=0, I_B=0 -> result=0, borrow_out=0.
REQ-032 Apply start with I_A=9, I_B=2, then pulse start with I_A=1, I_B=8 on the second SHIFT cycle -> single done pulse, result=7, borrow_out=0.
REQ-033 Assert reset on the second SHIFT cycle of 7-3 -> outputs 0 immediately, no done pulse; after release, 5-6 -> result=15, borrow_out=1.
REQ-034 Hold start=1 continuously with I_A=10, I_B=4 -> done pulses every 6 cycles with result=6, borrow_out=0; busy is never high together with done.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues requests and the slave side (the subtractor) returns the difference.
interface serial_subtractor_if #(
    parameter int BIT = 4
);
    logic           start;
    logic [BIT-1:0] I_A;
    logic [BIT-1:0] I_B;
    logic [BIT-1:0] result;
    logic           borrow_out;
    logic           busy;
    logic           done;

    modport master (
        output start, I_A, I_B,
        input  result, borrow_out, busy, done
    );

    modport slave (
        input  start, I_A, I_B,
        output result, borrow_out, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A - B mod 2^BIT one bit per clock, LSB first.
// The difference bits shift into the top of the A register, so A holds the result when done.
module serial_subtractor #(
    parameter int BIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(BIT + 1);
    localparam logic [CNT_W-1:0] LastShift = CNT_W'(BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [BIT-1:0]   a_q;
    logic [BIT-1:0]   b_q;
    logic             borrow_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;

    logic diffBit_d;
    logic borrow_d;

    // One full-subtractor cell working on the current LSBs of A and B.
    always_comb begin
        diffBit_d = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.I_A;
                        b_q      <= bus.I_B;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= SHIFT;
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_q      <= {diffBit_d, a_q[BIT-1:1]};
                    b_q      <= {1'b0, b_q[BIT-1:1]};
                    borrow_q <= borrow_d;
                    count_q  <= count_q + CNT_W'(1);
                    // The last shift lands the MSB of the difference; go report it.
                    if (count_q == LastShift) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result     = a_q;
    assign bus.borrow_out = borrow_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (BIT=4): vector table, hand-built corner
// sequences, and randomized operands checked against plain modular arithmetic.
module tb_serial_subtractor;
    localparam int BIT = 4;

    typedef struct {
        logic [BIT-1:0] a;
        logic [BIT-1:0] b;
        logic [BIT-1:0] expResult;
        logic           expBorrow;
    } vec_t;

    logic clk;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;

    serial_subtractor_if #(.BIT(BIT)) bus ();

    serial_subtractor #(.BIT(BIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse start for one accepting edge; afterwards scramble the operand inputs,
    // which must not disturb the operation in flight.
    task automatic applyStimulus(input logic [BIT-1:0] a, input logic [BIT-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.I_A   = a;
        bus.I_B   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.I_A   = BIT'($urandom);
        bus.I_B   = BIT'($urandom);
    endtask

    task automatic runOp(input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                         input logic [BIT-1:0] expR, input logic expB, input string name);
        int busyCycles;
        bit found;
        busyCycles = 0;
        found = 1'b0;
        applyStimulus(a, b);
        for (int i = 0; i < 12 && !found; i++) begin
            if (bus.done) found = 1'b1;
            else begin
                if (bus.busy) busyCycles++;
                @(negedge clk);
            end
        end
        checkOutput({name, ".doneSeen"}, 32'(found), 32'd1);
        checkOutput({name, ".busyCycles"}, busyCycles, BIT);
        checkOutput({name, ".busyWithDone"}, 32'(bus.busy), 32'd0);
        checkOutput({name, ".result"}, 32'(bus.result), 32'(expR));
        checkOutput({name, ".borrow"}, 32'(bus.borrow_out), 32'(expB));
        @(negedge clk);
        checkOutput({name, ".donePulseWidth"}, 32'(bus.done), 32'd0);
        checkOutput({name, ".resultHold"}, 32'(bus.result), 32'(expR));
        checkOutput({name, ".borrowHold"}, 32'(bus.borrow_out), 32'(expB));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        int doneCount;
        logic [BIT-1:0] seenResult;
        logic seenBorrow;
        int prevIdx;
        int bothHigh;
        int a;
        int b;

        vecs.push_back('{4'd7,  4'd3,  4'd4,  1'b0});
        vecs.push_back('{4'd3,  4'd7,  4'd12, 1'b1});
        vecs.push_back('{4'd0,  4'd1,  4'd15, 1'b1});
        vecs.push_back('{4'd15, 4'd15, 4'd0,  1'b0});
        vecs.push_back('{4'd0,  4'd0,  4'd0,  1'b0});
        vecs.push_back('{4'd8,  4'd9,  4'd15, 1'b1});
        vecs.push_back('{4'd12, 4'd5,  4'd7,  1'b0});
        vecs.push_back('{4'd15, 4'd0,  4'd15, 1'b0});

        // Reset state, with start held high to show it is ignored during reset.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.I_A   = 4'd9;
        bus.I_B   = 4'd1;
        #1;
        checkOutput("reset.result", 32'(bus.result), 32'd0);
        checkOutput("reset.borrow", 32'(bus.borrow_out), 32'd0);
        checkOutput("reset.busy", 32'(bus.busy), 32'd0);
        checkOutput("reset.done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("resetStart.busy", 32'(bus.busy), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("afterReset.busy", 32'(bus.busy), 32'd0);

        foreach (vecs[i])
            runOp(vecs[i].a, vecs[i].b, vecs[i].expResult, vecs[i].expBorrow,
                  $sformatf("vec%0d", i));

        // A second start during SHIFT is dropped, not queued.
        applyStimulus(4'd9, 4'd2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.I_A   = 4'd1;
        bus.I_B   = 4'd8;
        @(negedge clk);
        bus.start = 1'b0;
        doneCount = 0;
        seenResult = '0;
        seenBorrow = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) begin
                doneCount++;
                seenResult = bus.result;
                seenBorrow = bus.borrow_out;
            end
            @(negedge clk);
        end
        checkOutput("overlap.doneCount", doneCount, 1);
        checkOutput("overlap.result", 32'(seenResult), 32'd7);
        checkOutput("overlap.borrow", 32'(seenBorrow), 32'd0);

        // Reset in the middle of SHIFT aborts with no done pulse.
        applyStimulus(4'd7, 4'd3);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        #1;
        checkOutput("abort.result", 32'(bus.result), 32'd0);
        checkOutput("abort.borrow", 32'(bus.borrow_out), 32'd0);
        checkOutput("abort.busy", 32'(bus.busy), 32'd0);
        checkOutput("abort.done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("abort.noDone", doneCount, 0);
        runOp(4'd5, 4'd6, 4'd15, 1'b1, "postAbort");

        // Start held high: back-to-back operations every BIT+2 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.I_A   = 4'd10;
        bus.I_B   = 4'd4;
        doneCount = 0;
        prevIdx   = -1;
        bothHigh  = 0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            if (bus.busy && bus.done) bothHigh++;
            if (bus.done) begin
                doneCount++;
                checkOutput("hold.result", 32'(bus.result), 32'd6);
                checkOutput("hold.borrow", 32'(bus.borrow_out), 32'd0);
                if (prevIdx >= 0) checkOutput("hold.period", i - prevIdx, BIT + 2);
                prevIdx = i;
            end
        end
        bus.start = 1'b0;
        checkOutput("hold.doneCount", doneCount, 7);
        checkOutput("hold.busyAndDone", bothHigh, 0);
        repeat (3) @(negedge clk);

        // Randomized operands against modular arithmetic.
        for (int n = 0; n < 25; n++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            runOp(BIT'(a), BIT'(b), BIT'((a - b + 16) % 16), (a < b),
                  $sformatf("rand%0d_%0d_%0d", n, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
